// File: rtl/nvram_uploader_pkg.sv
// Shared types and defaults for the NVRAM uploader.
package nvram_uploader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        VALID,
        FINISH
    } state_t;

    localparam logic [7:0] NV_INDEX_DEFAULT = 8'hFF;
    localparam int         DEPTH_DEFAULT    = 256;

endpackage

// File: rtl/nvram_rd_delay.sv
// Delays the CMOS read enable by the RAM read latency to mark when ram_q is valid.
module nvram_rd_delay #(
    parameter int RD_LAT = 1
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic clear,
    input  logic ram_rd,
    output logic capture
);

    logic [RD_LAT-1:0] taps;

    // Shift the read strobe along; clearing drops a read left behind by an aborted upload.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            taps <= '0;
        end else if (clear) begin
            taps <= '0;
        end else begin
            taps <= (taps << 1) | RD_LAT'(ram_rd);
        end
    end

    assign capture = taps[RD_LAT-1];

endmodule

// File: rtl/nvram_uploader.sv
// Streams CMOS bytes to the host during an NVRAM upload and tracks whether CMOS changed.
module nvram_uploader
    import nvram_uploader_pkg::*;
#(
    parameter int         DEPTH    = DEPTH_DEFAULT,
    parameter logic [7:0] NV_INDEX = NV_INDEX_DEFAULT,
    parameter int         RD_LAT   = 1
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ioctl_upl,
    input  logic [7:0] ioctl_index,
    input  logic       ioctl_rd,
    output logic [7:0] ioctl_din,
    output logic [7:0] ram_addr,
    output logic       ram_rd,
    input  logic [7:0] ram_q,
    input  logic       cmos_wr,
    output logic       dirty,
    output logic       busy,
    output logic       done
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    state_t           state, state_next;
    logic [PTR_W-1:0] ptr, ptr_next;
    logic             pending, pending_next;
    logic [7:0]       din_next;
    logic             dirty_next, done_next;
    logic             wr_seen, wr_seen_next;
    logic             upl_q;
    logic             start;
    logic             advance;
    logic             capture;
    logic             delay_clear;

    assign start       = ioctl_upl && !upl_q && (ioctl_index == NV_INDEX);
    assign delay_clear = (state == IDLE);
    assign ram_rd      = (state == FETCH);
    assign ram_addr    = 8'(ptr);
    assign busy        = (state != IDLE);

    nvram_rd_delay #(
        .RD_LAT (RD_LAT)
    ) u_rd_delay (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clear   (delay_clear),
        .ram_rd  (ram_rd),
        .capture (capture)
    );

    // Register FSM state, pointer, host byte and status; upl_q resets high so a held upload needs a fresh edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            pending   <= 1'b0;
            ioctl_din <= 8'h00;
            dirty     <= 1'b0;
            done      <= 1'b0;
            wr_seen   <= 1'b0;
            upl_q     <= 1'b1;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            pending   <= pending_next;
            ioctl_din <= din_next;
            dirty     <= dirty_next;
            done      <= done_next;
            wr_seen   <= wr_seen_next;
            upl_q     <= ioctl_upl;
        end
    end

    // Next-state logic: fetch, wait for data, present it, advance on host read; upload drop aborts or completes.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        pending_next = pending;
        din_next     = ioctl_din;
        dirty_next   = dirty | cmos_wr;
        done_next    = 1'b0;
        wr_seen_next = wr_seen | cmos_wr;
        advance      = ioctl_rd | pending;

        case (state)
            IDLE: begin
                pending_next = 1'b0;
                if (start) begin
                    state_next   = FETCH;
                    ptr_next     = '0;
                    wr_seen_next = cmos_wr;
                end
            end
            FETCH: begin
                if (!ioctl_upl) begin
                    state_next   = IDLE;
                    pending_next = 1'b0;
                end else begin
                    state_next = WAIT;
                    if (ioctl_rd) pending_next = 1'b1;
                end
            end
            WAIT: begin
                if (!ioctl_upl) begin
                    state_next   = IDLE;
                    pending_next = 1'b0;
                end else begin
                    if (ioctl_rd) pending_next = 1'b1;
                    if (capture) begin
                        din_next   = ram_q;
                        state_next = VALID;
                    end
                end
            end
            VALID: begin
                if (!ioctl_upl) begin
                    state_next   = IDLE;
                    pending_next = 1'b0;
                end else if (advance) begin
                    pending_next = 1'b0;
                    if (ptr == LAST) begin
                        state_next = FINISH;
                    end else begin
                        ptr_next   = ptr + PTR_W'(1);
                        state_next = FETCH;
                    end
                end
            end
            FINISH: begin
                if (!ioctl_upl) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    dirty_next = cmos_wr | (dirty & wr_seen);
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/nvram_uploader.md
NVRAM_UPLOADER -- requirements
Module: nvram_uploader

Interface
REQ-001 SHALL have parameter DEPTH, default 256: CMOS bytes returned per upload.
REQ-002 SHALL have parameter NV_INDEX, default 8'hFF: ioctl_index value that selects NVRAM upload.
REQ-003 SHALL have parameter RD_LAT, default 1: ram_q read latency in clk_sys cycles, range 1-3.
REQ-004 SHALL have port clk_sys  in  1: single clock, all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port ioctl_upl  in  1: host upload active.
REQ-007 SHALL have port ioctl_index  in  8: upload target selector.
REQ-008 SHALL have port ioctl_rd  in  1: one-cycle strobe; host consumed ioctl_din.
REQ-009 SHALL have port ioctl_din  out  8: byte presented to host.
REQ-010 SHALL have port ram_addr  out  8: CMOS read address.
REQ-011 SHALL have port ram_rd  out  1: one-cycle CMOS read enable.
REQ-012 SHALL have port ram_q  in  8: CMOS read data, valid RD_LAT cycles after ram_rd.
REQ-013 SHALL have port cmos_wr  in  1: game CPU write to CMOS.
REQ-014 SHALL have port dirty  out  1: CMOS changed since last complete upload.
REQ-015 SHALL have port busy  out  1: upload in progress.
REQ-016 SHALL have port done  out  1: one-cycle pulse on successful completion.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WAIT, VALID, FINISH.
REQ-018 IDLE->FETCH SHALL occur on the cycle after ioctl_upl rises while ioctl_index==NV_INDEX; ptr<=0. Other indices SHALL be ignored.
REQ-019 FETCH SHALL last one cycle: ram_rd=1, ram_addr=ptr. Next state is WAIT.
REQ-020 WAIT SHALL last RD_LAT cycles, then ioctl_din<=ram_q. Next state is VALID.
REQ-021 First byte SHALL be valid at most 2+RD_LAT cycles after ioctl_upl rises.
REQ-022 In VALID, ioctl_rd SHALL advance: if ptr==DEPTH-1 go to FINISH, else ptr<=ptr+1 and go to FETCH.
REQ-023 ioctl_rd in FETCH or WAIT SHALL set a one-deep pending flag. On entry to VALID with pending set, VALID SHALL act as if ioctl_rd were asserted and clear the flag.
REQ-024 A second ioctl_rd while pending is already set SHALL be dropped; no byte is skipped.
REQ-025 ioctl_din SHALL hold its value except at WAIT exit; in FINISH it SHALL hold byte DEPTH-1.
REQ-026 In FINISH, further ioctl_rd SHALL be ignored; ptr SHALL not wrap.
REQ-027 On ioctl_upl fall while in FINISH: go to IDLE, pulse done for 1 cycle, clear dirty unless cmos_wr occurred at any time since the upload began.
REQ-028 On ioctl_upl fall in FETCH, WAIT or VALID (abort): go to IDLE, no done, dirty unchanged, pending cleared.
REQ-029 cmos_wr SHALL set dirty in every state. If cmos_wr coincides with the done cycle, dirty SHALL end at 1.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 ptr SHALL be $clog2(DEPTH) bits wide; ram_addr SHALL be ptr zero-extended or truncated to 8 bits.

Reset
REQ-032 reset_n low SHALL asynchronously force: state=IDLE, ptr=0, pending=0, ioctl_din=8'h00, ram_rd=0, ram_addr=0, dirty=0, busy=0, done=0.
REQ-033 Reset asserted mid-upload SHALL abort the upload. After release, a new ioctl_upl rising edge is required to start again.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, NV_INDEX_DEFAULT (8'hFF) and DEPTH_DEFAULT (256).
REQ-035 The RD_LAT alignment SHALL be one sub-module, nvram_rd_delay: a shift register that delays ram_rd into a capture strobe.

Verification
REQ-036 Test 1: RAM preloaded with byte i = i^8'h5A; upload with ioctl_rd every 4 cycles. Expect 256 bytes in order, byte 0 = 8'h5A, byte 255 = 8'hA5, then done pulses once on ioctl_upl fall.
REQ-037 Test 2: ioctl_rd issued the cycle after each VALID entry, back-to-back (maximum rate). Expect no skipped or duplicated bytes.
REQ-038 Test 3: ioctl_index=8'h00 with ioctl_upl pulsed. Expect busy=0, ram_rd never asserted.
REQ-039 Test 4: cmos_wr, then full upload. Expect dirty=0 after done. Repeat with cmos_wr during byte 100: expect dirty=1 after done.
REQ-040 Test 5: ioctl_upl dropped after byte 37. Expect IDLE next cycle, no done, dirty unchanged. Restart: expect first byte is again RAM[0].
REQ-041 Test 6: reset_n low while in WAIT. Expect all outputs at reset values immediately, without waiting for a clock edge. Run with RD_LAT=3 and expect identical data.
